// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcoded control FSM for a two-register load/store datapath
// Three-process Moore FSM; T3-T5 behaviour is selected by the opcode held in IR.
module control_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [4:0] op,
  input  logic       mem_ready,
  output logic       pco,
  output logic       iro,
  output logic       maro,
  output logic       mdro,
  output logic       r0o,
  output logic       r1o,
  output logic       pcin,
  output logic       irin,
  output logic       marin,
  output logic       mdrin,
  output logic       r0in,
  output logic       r1in,
  output logic       incpc,
  output logic       read,
  output logic       write,
  output logic       done,
  output logic [3:0] step
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_HALT = 4'd15;

  localparam logic [4:0] OP_LD  = 5'b00000;
  localparam logic [4:0] OP_ST  = 5'b00001;
  localparam logic [4:0] OP_MOV = 5'b00010;
  localparam logic [4:0] OP_HLT = 5'b00011;

  logic [3:0] state_q;
  logic [3:0] state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: state_d = run ? S_T0 : S_IDLE;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = mem_ready ? S_T2 : S_T1;
      S_T2:   state_d = S_T3;
      S_T3: begin
        case (op)
          OP_LD, OP_ST: state_d = S_T4;
          OP_HLT:       state_d = S_HALT;
          default:      state_d = S_T0;
        endcase
      end
      S_T4: begin
        if (op == OP_LD) begin
          state_d = mem_ready ? S_T5 : S_T4;
        end else if (op == OP_ST) begin
          state_d = S_T5;
        end else begin
          state_d = S_T0;
        end
      end
      S_T5: begin
        // Only a store waits here; a load has already completed its read in T4.
        if (op == OP_ST) begin
          state_d = mem_ready ? S_T0 : S_T5;
        end else begin
          state_d = S_T0;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pco   = 1'b0;
    iro   = 1'b0;
    maro  = 1'b0;
    mdro  = 1'b0;
    r0o   = 1'b0;
    r1o   = 1'b0;
    pcin  = 1'b0;
    irin  = 1'b0;
    marin = 1'b0;
    mdrin = 1'b0;
    r0in  = 1'b0;
    r1in  = 1'b0;
    incpc = 1'b0;
    read  = 1'b0;
    write = 1'b0;
    done  = 1'b0;
    case (state_q)
      S_T0: begin
        pco   = 1'b1;
        marin = 1'b1;
        incpc = 1'b1;
      end
      S_T1: begin
        read  = 1'b1;
        mdrin = 1'b1;
      end
      S_T2: begin
        mdro = 1'b1;
        irin = 1'b1;
      end
      S_T3: begin
        if (op == OP_LD || op == OP_ST) begin
          r1o   = 1'b1;
          marin = 1'b1;
        end else if (op == OP_MOV) begin
          r1o  = 1'b1;
          r0in = 1'b1;
        end
      end
      S_T4: begin
        if (op == OP_LD) begin
          read  = 1'b1;
          mdrin = 1'b1;
        end else if (op == OP_ST) begin
          r0o   = 1'b1;
          mdrin = 1'b1;
        end
      end
      S_T5: begin
        if (op == OP_LD) begin
          mdro = 1'b1;
          r0in = 1'b1;
        end else if (op == OP_ST) begin
          write = 1'b1;
        end
      end
      S_HALT:  done = 1'b1;
      default: ;
    endcase
  end

  assign step = state_q;

endmodule
